// File: rtl/spdif_stream_scheduler_if.sv
// rtl/spdif_stream_scheduler_if.sv - source pair and frame-encoder sample handshake bundle
interface spdif_stream_scheduler_if;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_left;
    logic [23:0] s_right;
    logic        enc_valid;
    logic        enc_ready;
    logic        enc_is_left;
    logic [23:0] enc_audio;
    logic        enc_user;
    logic        enc_control;
    logic [8:0]  enc_sub_frame_number;

    modport master (
        output s_valid, s_left, s_right, enc_ready, enc_sub_frame_number,
        input  s_ready, enc_valid, enc_is_left, enc_audio, enc_user, enc_control
    );

    modport slave (
        input  s_valid, s_left, s_right, enc_ready, enc_sub_frame_number,
        output s_ready, enc_valid, enc_is_left, enc_audio, enc_user, enc_control
    );
endinterface

// File: rtl/spdif_stream_scheduler.sv
// rtl/spdif_stream_scheduler.sv - feeds stereo pairs to the S/PDIF frame encoder with channel-status bits
module spdif_stream_scheduler #(
    parameter logic [7:0] CATEGORY = 8'h00
) (
    input  logic                         clk128,
    input  logic                         reset,
    spdif_stream_scheduler_if.slave      bus,
    input  logic                         cfg_copy_permit,
    input  logic                         cfg_pre_emphasis,
    input  logic [3:0]                   cfg_sample_rate,
    input  logic [3:0]                   cfg_word_length,
    input  logic                         cfg_mute,
    input  logic                         cfg_fill_silence,
    output logic [15:0]                  silence_count
);
    typedef enum logic [1:0] {IDLE, SEND_L, SEND_R} state_t;

    state_t      state;
    state_t      state_next;
    logic        load_pair;
    logic        load_silence;
    logic        enc_fire;
    logic [23:0] left_q;
    logic [23:0] right_q;
    logic        copy_sh;
    logic        pre_sh;
    logic [3:0]  rate_sh;
    logic [3:0]  wlen_sh;
    logic [7:0]  cs_index;
    logic        cs_bit;

    always_ff @(posedge clk128) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next        = state;
        load_pair         = 1'b0;
        load_silence      = 1'b0;
        bus.s_ready       = 1'b0;
        bus.enc_valid     = 1'b0;
        bus.enc_is_left   = 1'b0;
        bus.enc_audio     = 24'd0;
        case (state)
            IDLE: begin
                bus.s_ready = 1'b1;
                if (bus.s_valid) begin
                    load_pair  = 1'b1;
                    state_next = SEND_L;
                end else if (cfg_fill_silence && bus.enc_ready) begin
                    load_silence = 1'b1;
                    state_next   = SEND_L;
                end
            end
            SEND_L: begin
                bus.enc_valid   = 1'b1;
                bus.enc_is_left = 1'b1;
                bus.enc_audio   = left_q;
                if (bus.enc_ready) state_next = SEND_R;
            end
            SEND_R: begin
                bus.enc_valid = 1'b1;
                bus.enc_audio = right_q;
                if (bus.enc_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign enc_fire = bus.enc_valid && bus.enc_ready;

    // Mute is applied at capture so a pair already held is never altered.
    always_ff @(posedge clk128) begin
        if (reset) begin
            left_q  <= 24'd0;
            right_q <= 24'd0;
        end else if (load_pair) begin
            left_q  <= cfg_mute ? 24'd0 : bus.s_left;
            right_q <= cfg_mute ? 24'd0 : bus.s_right;
        end else if (load_silence) begin
            left_q  <= 24'd0;
            right_q <= 24'd0;
        end
    end

    always_ff @(posedge clk128) begin
        if (reset)                                    silence_count <= 16'd0;
        else if (load_silence && silence_count != 16'hFFFF) silence_count <= silence_count + 16'd1;
    end

    // Shadows only move at the start of a block so all 192 frames carry one consistent CS word.
    always_ff @(posedge clk128) begin
        if (reset) begin
            copy_sh <= 1'b0;
            pre_sh  <= 1'b0;
            rate_sh <= 4'd0;
            wlen_sh <= 4'd0;
        end else if (enc_fire && bus.enc_sub_frame_number == 9'd0) begin
            copy_sh <= cfg_copy_permit;
            pre_sh  <= cfg_pre_emphasis;
            rate_sh <= cfg_sample_rate;
            wlen_sh <= cfg_word_length;
        end
    end

    assign cs_index = bus.enc_sub_frame_number[8:1];

    always_comb begin
        cs_bit = 1'b0;
        if (cs_index == 8'd2)                          cs_bit = copy_sh;
        else if (cs_index == 8'd3)                     cs_bit = pre_sh;
        else if (cs_index >= 8'd8 && cs_index <= 8'd15)  cs_bit = CATEGORY[cs_index[2:0]];
        else if (cs_index >= 8'd24 && cs_index <= 8'd27) cs_bit = rate_sh[cs_index[1:0]];
        else if (cs_index >= 8'd32 && cs_index <= 8'd35) cs_bit = wlen_sh[cs_index[1:0]];
    end

    assign bus.enc_control = cs_bit;
    assign bus.enc_user    = 1'b0;
endmodule

// File: tb/tb_spdif_stream_scheduler.sv
// tb/tb_spdif_stream_scheduler.sv - directed scoreboard bench for spdif_stream_scheduler
module tb_spdif_stream_scheduler;
    logic        clk128 = 1'b0;
    logic        reset;
    logic        cfg_copy_permit;
    logic        cfg_pre_emphasis;
    logic [3:0]  cfg_sample_rate;
    logic [3:0]  cfg_word_length;
    logic        cfg_mute;
    logic        cfg_fill_silence;
    logic [15:0] silence_count;

    spdif_stream_scheduler_if bus ();

    spdif_stream_scheduler #(.CATEGORY(8'h82)) dut (
        .clk128           (clk128),
        .reset            (reset),
        .bus              (bus),
        .cfg_copy_permit  (cfg_copy_permit),
        .cfg_pre_emphasis (cfg_pre_emphasis),
        .cfg_sample_rate  (cfg_sample_rate),
        .cfg_word_length  (cfg_word_length),
        .cfg_mute         (cfg_mute),
        .cfg_fill_silence (cfg_fill_silence),
        .silence_count    (silence_count)
    );

    always #5 clk128 = ~clk128;

    int          passed = 0;
    int          total  = 0;
    int          pops   = 0;
    logic [15:0] exp_sil = 16'd0;
    logic [24:0] sb[$];

    task automatic check(string tag, logic [47:0] obs, logic [47:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Model reacts to handshakes visible before the coming edge, then advances one cycle.
    task automatic step();
        logic [24:0] e;
        if (!reset) begin
            if (bus.enc_valid && bus.enc_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 48'd1, 48'd0);
                end else begin
                    e = sb.pop_front();
                    pops++;
                    check("sb_subframe", {23'd0, bus.enc_is_left, bus.enc_audio}, {23'd0, e});
                end
            end
            if (bus.s_ready) begin
                if (bus.s_valid) begin
                    sb.push_back({1'b1, cfg_mute ? 24'd0 : bus.s_left});
                    sb.push_back({1'b0, cfg_mute ? 24'd0 : bus.s_right});
                end else if (cfg_fill_silence && bus.enc_ready) begin
                    sb.push_back({1'b1, 24'd0});
                    sb.push_back({1'b0, 24'd0});
                    if (exp_sil != 16'hFFFF) exp_sil++;
                end
            end
        end else begin
            sb.delete();
            exp_sil = 16'd0;
        end
        @(posedge clk128);
        @(negedge clk128);
    endtask

    task automatic send_pair(logic [23:0] l, logic [23:0] r);
        bus.s_left  = l;
        bus.s_right = r;
        bus.s_valid = 1'b1;
        step();
        bus.s_valid = 1'b0;
        step();
        step();
    endtask

    function automatic bit exp_cs(int frame, int mode);
        if (mode == 0) return frame inside {2, 9, 15, 25, 32, 33, 35};
        return frame inside {3, 9, 15, 24, 26};
    endfunction

    task automatic sweep(int mode);
        for (int s = 0; s < 384; s++) begin
            bus.enc_sub_frame_number = s[8:0];
            #1;
            check($sformatf("cs_m%0d_sf%0d", mode, s), {47'd0, bus.enc_control}, {47'd0, exp_cs(s / 2, mode)});
        end
        @(negedge clk128);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        reset = 1'b1;
        cfg_copy_permit = 1'b0; cfg_pre_emphasis = 1'b0;
        cfg_sample_rate = 4'd0; cfg_word_length = 4'd0;
        cfg_mute = 1'b0; cfg_fill_silence = 1'b0;
        bus.s_valid = 1'b0; bus.s_left = 24'd0; bus.s_right = 24'd0;
        bus.enc_ready = 1'b0; bus.enc_sub_frame_number = 9'd0;
        @(negedge clk128);
        step();
        step();
        check("rst_s_ready", {47'd0, bus.s_ready}, 48'd1);
        check("rst_enc_valid", {47'd0, bus.enc_valid}, 48'd0);
        check("rst_is_left", {47'd0, bus.enc_is_left}, 48'd0);
        check("rst_audio", {24'd0, bus.enc_audio}, 48'd0);
        check("rst_silence", {32'd0, silence_count}, 48'd0);
        check("enc_user", {47'd0, bus.enc_user}, 48'd0);
        reset = 1'b0;
        step();

        // Basic pair with immediate encoder acceptance
        bus.enc_ready = 1'b1;
        bus.s_left = 24'h123456; bus.s_right = 24'hABCDEF; bus.s_valid = 1'b1;
        step();
        bus.s_valid = 1'b0;
        check("lat_valid_n1", {47'd0, bus.enc_valid}, 48'd1);
        check("lat_left_n1", {47'd0, bus.enc_is_left}, 48'd1);
        check("lat_audio_n1", {24'd0, bus.enc_audio}, 48'h123456);
        check("lat_s_ready_n1", {47'd0, bus.s_ready}, 48'd0);
        step();
        check("lat_valid_n2", {47'd0, bus.enc_valid}, 48'd1);
        check("lat_left_n2", {47'd0, bus.enc_is_left}, 48'd0);
        check("lat_audio_n2", {24'd0, bus.enc_audio}, 48'hABCDEF);
        step();
        check("lat_s_ready_n3", {47'd0, bus.s_ready}, 48'd1);
        check("lat_valid_n3", {47'd0, bus.enc_valid}, 48'd0);

        // Encoder back-pressure holds SEND_L
        bus.s_left = 24'h654321; bus.s_right = 24'h0FEDCB; bus.s_valid = 1'b1;
        step();
        bus.s_valid = 1'b0;
        bus.enc_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("stall_valid_%0d", i), {47'd0, bus.enc_valid}, 48'd1);
            check($sformatf("stall_left_%0d", i), {24'd0, bus.enc_is_left, bus.enc_audio}, {24'd0, 1'b1, 24'h654321});
            step();
        end
        bus.enc_ready = 1'b1;
        step();
        check("stall_to_right", {24'd0, bus.enc_is_left, bus.enc_audio}, {24'd0, 1'b0, 24'h0FEDCB});
        step();
        check("stall_done_ready", {47'd0, bus.s_ready}, 48'd1);

        // Silence insertion on starvation
        p0 = pops;
        cfg_fill_silence = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (bus.s_ready && exp_sil == 16'd3) cfg_fill_silence = 1'b0;
            step();
        end
        cfg_fill_silence = 1'b0;
        check("sil_count3", {32'd0, silence_count}, 48'd3);
        check("sil_subframes6", 48'(pops - p0), 48'd6);
        check("sil_sb_empty", 48'(sb.size()), 48'd0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("nofill_valid_%0d", i), {47'd0, bus.enc_valid}, 48'd0);
            step();
        end
        check("nofill_count", {32'd0, silence_count}, 48'd3);

        // Mute applies at capture only
        cfg_mute = 1'b1;
        bus.s_left = 24'hAAAAAA; bus.s_right = 24'h555555; bus.s_valid = 1'b1;
        step();
        bus.s_valid = 1'b0;
        cfg_mute = 1'b0;
        check("mute_zeroed", {24'd0, bus.enc_audio}, 48'd0);
        step();
        step();
        bus.s_left = 24'h111111; bus.s_right = 24'h222222; bus.s_valid = 1'b1;
        step();
        bus.s_valid = 1'b0;
        cfg_mute = 1'b1;
        check("mute_late_left", {24'd0, bus.enc_audio}, 48'h111111);
        step();
        check("mute_late_right", {24'd0, bus.enc_audio}, 48'h222222);
        step();
        cfg_mute = 1'b0;

        // Channel status block, then mid-block config change
        cfg_copy_permit = 1'b1; cfg_sample_rate = 4'h2; cfg_word_length = 4'hB; cfg_pre_emphasis = 1'b0;
        bus.enc_sub_frame_number = 9'd0;
        send_pair(24'h000001, 24'h000002);
        sweep(0);
        cfg_copy_permit = 1'b0; cfg_sample_rate = 4'h5; cfg_word_length = 4'h0; cfg_pre_emphasis = 1'b1;
        sweep(0);
        bus.enc_sub_frame_number = 9'd7;
        send_pair(24'h000003, 24'h000004);
        sweep(0);
        bus.enc_sub_frame_number = 9'd0;
        send_pair(24'h000005, 24'h000006);
        sweep(1);

        // Reset while SEND_R is holding a subframe
        bus.enc_sub_frame_number = 9'd0;
        cfg_fill_silence = 1'b1;
        step();
        cfg_fill_silence = 1'b0;
        step();
        step();
        check("pre_rst_count", {32'd0, silence_count}, 48'd4);
        bus.s_left = 24'h777777; bus.s_right = 24'h888888; bus.s_valid = 1'b1;
        step();
        bus.s_valid = 1'b0;
        step();
        check("in_send_r", {24'd0, bus.enc_is_left, bus.enc_audio}, {24'd0, 1'b0, 24'h888888});
        reset = 1'b1;
        bus.s_valid = 1'b1;
        step();
        bus.s_valid = 1'b0;
        check("rst_r_valid", {47'd0, bus.enc_valid}, 48'd0);
        check("rst_r_count", {32'd0, silence_count}, 48'd0);
        check("rst_r_s_ready", {47'd0, bus.s_ready}, 48'd1);
        check("rst_r_audio", {24'd0, bus.enc_audio}, 48'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("post_rst_valid_%0d", i), {47'd0, bus.enc_valid}, 48'd0);
            step();
        end
        check("final_sb_empty", 48'(sb.size()), 48'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/spdif_stream_scheduler.md
SPDIF_STREAM_SCHEDULER -- requirements
Module: spdif_stream_scheduler

Interface
REQ-001 SHALL have parameter CATEGORY, default 8'h00: channel-status category code, CS bits 8..15, LSB at bit 8.
REQ-002 SHALL have port clk128 input 1: sole clock, 128x sample rate; all logic on rising edge.
REQ-003 SHALL have port reset input 1: synchronous, active-high reset.
REQ-004 SHALL have ports s_valid input 1, s_ready output 1: stereo-pair source handshake.
REQ-005 SHALL have ports s_left input 24, s_right input 24: pair samples, transferred when s_valid && s_ready.
REQ-006 SHALL have cfg_copy_permit input 1, cfg_pre_emphasis input 1, cfg_sample_rate input 4, cfg_word_length input 4: channel-status fields.
REQ-007 SHALL have cfg_mute input 1 (zero consumed audio) and cfg_fill_silence input 1 (insert zero pairs on starvation).
REQ-008 SHALL have enc_valid output 1 and enc_ready input 1: frame-encoder sample handshake.
REQ-009 SHALL have enc_is_left output 1, enc_audio output 24, enc_user output 1, enc_control output 1: encoder sample fields.
REQ-010 SHALL have enc_sub_frame_number input 9: encoder's current subframe index, 0..383.
REQ-011 SHALL have silence_count output 16: number of inserted silence pairs.

Function
REQ-012 SHALL implement FSM states IDLE, SEND_L, SEND_R.
REQ-013 IDLE: s_ready=1, enc_valid=0; all other states: s_ready=0.
REQ-014 IDLE, s_valid=1: register pair (zeroed if cfg_mute=1 at that cycle); next state SEND_L.
REQ-015 IDLE, s_valid=0, cfg_fill_silence=1, enc_ready=1: register zero pair; next SEND_L; silence_count +1, saturating at 16'hFFFF.
REQ-016 IDLE otherwise: stay IDLE; no counter change.
REQ-017 SEND_L: enc_valid=1, enc_is_left=1, enc_audio=left register; on enc_ready=1 next SEND_R.
REQ-018 SEND_R: enc_valid=1, enc_is_left=0, enc_audio=right register; on enc_ready=1 next IDLE.
REQ-019 enc_valid, enc_is_left, enc_audio SHALL be stable while enc_valid=1 and enc_ready=0.
REQ-020 Latency: pair accepted at cycle N -> enc_valid=1 at N+1; at least one IDLE cycle between consecutive pairs.
REQ-021 enc_user SHALL be constant 0.
REQ-022 enc_control SHALL be combinational: CS bit k, k = enc_sub_frame_number[8:1]; both subframes of a frame carry the same bit.
REQ-023 CS map: bit0=0, bit1=0, bit2=copy_permit, bit3=pre_emphasis, bits8..15=CATEGORY, bits24..27=sample_rate (LSB at 24), bits32..35=word_length (LSB at 32); all other bits 0.
REQ-024 CS fields from cfg_* SHALL come from shadow registers, loaded from cfg_* on an enc handshake (enc_valid && enc_ready) with enc_sub_frame_number==0; CATEGORY is constant.
REQ-025 Shadows SHALL be otherwise unchanged, so the CS of a 192-frame block is consistent; frame 0 bits are constant 0 and independent of shadow timing.
REQ-026 cfg_mute SHALL affect only pairs accepted while asserted, never a pair already registered.
REQ-027 Encoder-side subframe-number resynchronisation (wrap 383->0, underrun restart) SHALL need no action: the scheduler indexes CS only from enc_sub_frame_number.

Reset
REQ-028 On reset=1 at a clock edge: state IDLE, s_ready=1 the following cycle, enc_valid=0, enc_is_left=0, enc_audio=0, pair registers 0, shadows 0, silence_count 0.
REQ-029 Reset mid-transfer (SEND_L/SEND_R) SHALL discard the held pair with no further enc_valid for it.
REQ-030 reset SHALL take priority over all other inputs in the same cycle.

Verification
REQ-031 Pair L=24'h123456, R=24'hABCDEF, enc_ready=1 -> enc_valid cycles N+1 (is_left=1, 123456) and N+2 (is_left=0, ABCDEF); s_ready=1 at N+3.
REQ-032 enc_ready=0 for 10 cycles in SEND_L -> outputs frozen for 10 cycles, then advance to SEND_R on the first enc_ready=1.
REQ-033 s_valid=0, cfg_fill_silence=1, enc_ready=1 for 3 pairs -> 6 zero subframes, silence_count=3; with cfg_fill_silence=0 -> enc_valid stays 0, count unchanged.
REQ-034 cfg_copy_permit=1, sample_rate=4'h2, word_length=4'hB, CATEGORY=8'h82, handshake at subframe 0, sweep 0..383 -> enc_control=1 exactly at frames 2, 9, 15, 25, 32, 33, 35; both subframes of each frame equal.
REQ-035 cfg change mid-block -> enc_control unchanged until next subframe-0 handshake.
REQ-036 reset asserted in SEND_R -> enc_valid=0 next cycle, silence_count=0, s_ready=1.
